// File: rtl/rr_decode_arbiter_if.sv
// rtl/rr_decode_arbiter_if.sv - request/grant bundle between requesters and the round-robin arbiter
//
// Signals:
//   req[3:0]     requester -> arbiter, req[i]=1 means requester i wants the resource
//   done         requester -> arbiter, current owner releases (ignored with no grant)
//   gnt[3:0]     arbiter -> requesters, one-hot grant, zero when idle
//   gnt_idx[1:0] arbiter -> requesters, binary owner index, holds last owner when idle
//   gnt_valid    arbiter -> requesters, a grant is active
//   timeout      arbiter -> requesters, one-cycle pulse after a forced release
// Modports: master = requester side, slave = arbiter side.

interface rr_decode_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - 4-requester round-robin arbiter with hold timeout and one-hot grant decode
//
// Parameters:
//   MAX_HOLD  maximum cycles one grant may last before forced release (1..255)
// Ports:
//   clk   system clock, rising-edge active
//   rst   asynchronous active-high reset
//   bus   rr_decode_arbiter_if.slave: req/done in, gnt/gnt_idx/gnt_valid/timeout out

module rr_decode_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input logic                 clk,
    input logic                 rst,
    rr_decode_arbiter_if.slave  bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] state;
    logic [1:0] last;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    logic [7:0] hold_cnt;

    logic [1:0] arb_base;
    logic [1:0] win_idx;
    logic       win_found;
    logic       owner_req;
    logic       hold_expired;
    logic       release_grant;

    // While granting, the owner being released becomes the new "last",
    // so the search base is the owner itself; when idle it is the stored last.
    always_comb begin
        arb_base = (state == GRANT) ? gnt_idx : last;
    end

    // Scan from base+4 (the base itself, lowest priority) down to base+1
    // (highest priority); the final hit therefore is the highest-priority one.
    always_comb begin
        logic [1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = arb_base;
        for (int k = 4; k >= 1; k--) begin
            cand = arb_base + 2'(k);
            if (bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_req     = bus.req[gnt_idx];
        hold_expired  = (hold_cnt == HOLD_LAST);
        release_grant = bus.done || !owner_req || hold_expired;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 2'd3;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= 8'd0;
        end else begin
            timeout <= 1'b0;
            if (state == IDLE) begin
                if (win_found) begin
                    gnt_idx   <= win_idx;
                    gnt_valid <= 1'b1;
                    hold_cnt  <= 8'd0;
                    state     <= GRANT;
                end
            end else begin
                if (release_grant) begin
                    last     <= gnt_idx;
                    hold_cnt <= 8'd0;
                    // Timeout is only flagged when it is the sole reason for release.
                    timeout  <= hold_expired && !bus.done && owner_req;
                    if (win_found) begin
                        gnt_idx <= win_idx;
                    end else begin
                        gnt_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end else begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.gnt       = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
    assign bus.gnt_idx   = gnt_idx;
    assign bus.gnt_valid = gnt_valid;
    assign bus.timeout   = timeout;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb/tb_rr_decode_arbiter.sv - self-checking bench for rr_decode_arbiter

module tb_rr_decode_arbiter;

    logic clk;
    logic rst;

    rr_decode_arbiter_if b ();
    rr_decode_arbiter_if b1 ();

    rr_decode_arbiter #(.MAX_HOLD(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    rr_decode_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        b.req   = 4'b0000;
        b.done  = 1'b0;
        b1.req  = 4'b0000;
        b1.done = 1'b0;
        rst     = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Grant must be one-hot or zero every cycle on both instances.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if ($countones(b.gnt) > 1 || $countones(b1.gnt) > 1) begin
                n_fail++;
                $display("FAIL onehot: got %b / %b expected at most one bit", b.gnt, b1.gnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // req, done -> gnt, idx, valid, timeout (sampled after the edge)
        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[8]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[9]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[10] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[11] = '{4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[12] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[13] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

        b.req   = 4'b0000;
        b.done  = 1'b0;
        b1.req  = 4'b0000;
        b1.done = 1'b0;
        rst     = 1'b1;
        #2;
        check("reset_gnt",   {4'b0, b.gnt},       8'h00);
        check("reset_valid", {7'b0, b.gnt_valid}, 8'h00);
        check("reset_idx",   {6'b0, b.gnt_idx},   8'h00);
        check("reset_to",    {7'b0, b.timeout},   8'h00);
        step();
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            b.req  = vecs[i].req;
            b.done = vecs[i].done;
            step();
            check($sformatf("vec%0d_gnt", i),   {4'b0, b.gnt},       {4'b0, vecs[i].gnt});
            check($sformatf("vec%0d_idx", i),   {6'b0, b.gnt_idx},   {6'b0, vecs[i].idx});
            check($sformatf("vec%0d_valid", i), {7'b0, b.gnt_valid}, {7'b0, vecs[i].valid});
            check($sformatf("vec%0d_to", i),    {7'b0, b.timeout},   {7'b0, vecs[i].to});
        end
        b.done = 1'b0;

        // Timeout rotation with MAX_HOLD=8, and one-cycle grants with MAX_HOLD=1.
        do_reset();
        b.req  = 4'b0011;
        b1.req = 4'b1111;
        for (int n = 0; n < 32; n++) begin
            step();
            check($sformatf("to_idx%0d", n),    {6'b0, b.gnt_idx},   8'((n / 8) % 2));
            check($sformatf("to_valid%0d", n),  {7'b0, b.gnt_valid}, 8'h01);
            check($sformatf("to_pulse%0d", n),  {7'b0, b.timeout},   8'((n > 0 && n % 8 == 0) ? 1 : 0));
            check($sformatf("mh1_idx%0d", n),   {6'b0, b1.gnt_idx},  8'(n % 4));
            check($sformatf("mh1_to%0d", n),    {7'b0, b1.timeout},  8'((n > 0) ? 1 : 0));
        end

        // Asynchronous reset in the middle of a grant.
        #2;
        rst = 1'b1;
        #1;
        check("arst_gnt",   {4'b0, b.gnt},       8'h00);
        check("arst_valid", {7'b0, b.gnt_valid}, 8'h00);
        check("arst_idx",   {6'b0, b.gnt_idx},   8'h00);
        b.req  = 4'b0000;
        b1.req = 4'b0000;
        step();
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            check($sformatf("idle_gnt%0d", n),   {4'b0, b.gnt},       8'h00);
            check($sformatf("idle_valid%0d", n), {7'b0, b.gnt_valid}, 8'h00);
        end

        // done coinciding with the final hold cycle releases without timeout.
        do_reset();
        b.req = 4'b0011;
        step();
        for (int n = 0; n < 7; n++) begin
            step();
            check($sformatf("sim_hold%0d", n), {6'b0, b.gnt_idx}, 8'h00);
        end
        b.done = 1'b1;
        step();
        b.done = 1'b0;
        check("sim_idx",   {6'b0, b.gnt_idx},   8'h01);
        check("sim_valid", {7'b0, b.gnt_valid}, 8'h01);
        check("sim_to",    {7'b0, b.timeout},   8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
